// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a counted, checksummed byte
// image from a host and writes it word by word while holding the core in reset.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR
  } state_t;

  state_t      state, state_n;
  logic [15:0] n_words;
  logic [23:0] word_part;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic        accept;
  logic [31:0] hdr_n;
  logic [31:0] capacity;
  logic [31:0] loaded_next;

  assign accept      = in_valid && in_ready;
  assign hdr_n       = {16'd0, n_words[15:8], in_data};
  assign capacity    = 32'd1 << ADDR_W;
  assign loaded_next = 32'(words_loaded) + 32'd1;

  // A count equal to the full capacity is legal, so the word index never wraps.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_n = HDR_HI;
      HDR_HI:          if (accept) state_n = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_n > capacity)    state_n = ERR;
          else if (hdr_n == 32'd0) state_n = CHK;
          else                     state_n = DATA;
        end
      end
      DATA:    if (accept && byte_cnt == 2'd3) state_n = WRITE;
      WRITE:   state_n = (loaded_next == {16'd0, n_words}) ? CHK : DATA;
      CHK:     if (accept) state_n = (in_data == csum) ? DONE : ERR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      word_part    <= '0;
      byte_cnt     <= '0;
      csum         <= '0;
    end else begin
      state    <= state_n;
      in_ready <= state_n inside {HDR_HI, HDR_LO, DATA, CHK};
      busy     <= state_n inside {HDR_HI, HDR_LO, DATA, WRITE, CHK};
      done     <= (state_n == DONE);
      error    <= (state_n == ERR);
      cpu_hold <= (state_n != DONE);
      imem_we  <= (state_n == WRITE);

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            words_loaded <= '0;
            byte_cnt     <= '0;
            csum         <= '0;
          end
        end
        HDR_HI: if (accept) n_words[15:8] <= in_data;
        HDR_LO: if (accept) n_words[7:0]  <= in_data;
        DATA: begin
          if (accept) begin
            csum      <= csum ^ in_data;
            byte_cnt  <= byte_cnt + 2'd1;
            word_part <= {word_part[15:0], in_data};
            // Address and data are latched as WRITE is entered and then held.
            if (byte_cnt == 2'd3) begin
              imem_addr  <= words_loaded[ADDR_W-1:0];
              imem_wdata <= {word_part, in_data};
            end
          end
        end
        WRITE:   words_loaded <= words_loaded + (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-stream model predicts the memory
// writes and final status, and a per-cycle monitor scores every write strobe.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int          total = 0;
  int          bad = 0;
  bit          monEn = 1'b0;
  logic [7:0]  stream[$];
  logic [7:0]  expAddrQ[$];
  logic [31:0] expDataQ[$];
  logic        expDone;
  logic        expErr;
  int          expWords;
  logic [7:0]  expCsum;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Model: derive the expected writes and final status from the byte stream alone.
  task automatic buildModel(output logic eDone, output logic eErr,
                            output int eWords, output logic [7:0] eCsum);
    int          n;
    logic [31:0] word;
    n      = {stream[0], stream[1]};
    eDone  = 1'b0;
    eErr   = 1'b0;
    eWords = 0;
    eCsum  = 8'h00;
    if (n > (1 << ADDR_W)) begin
      eErr = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      word = {stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]};
      for (int k = 0; k < 4; k++) eCsum = eCsum ^ stream[2+4*w+k];
      expAddrQ.push_back(w[7:0]);
      expDataQ.push_back(word);
    end
    eWords = n;
    if (stream[2+4*n] == eCsum) eDone = 1'b1;
    else                        eErr  = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("handshake_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Start is pulsed together with a junk valid byte that must not be taken.
  task automatic applyStimulus(input bit randGaps, input int startPulseAt);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < stream.size(); i++) begin
      if (randGaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      if (i == startPulseAt) begin
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
      end
      sendByte(stream[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic checkLoad(input string tag);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_done"}, done, expDone);
    checkOutput({tag, "_error"}, error, expErr);
    checkOutput({tag, "_cpu_hold"}, cpu_hold, !expDone);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_words_loaded"}, words_loaded, expWords);
    checkOutput({tag, "_writes_left"}, expAddrQ.size(), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_imem_we"}, imem_we, 0);
    checkOutput({tag, "_imem_addr"}, imem_addr, 0);
    checkOutput({tag, "_imem_wdata"}, imem_wdata, 0);
    checkOutput({tag, "_cpu_hold"}, cpu_hold, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  task automatic runScenario(input string tag, input bit randGaps, input int startPulseAt);
    buildModel(expDone, expErr, expWords, expCsum);
    applyStimulus(randGaps, startPulseAt);
    checkLoad(tag);
  endtask

  // Every write strobe must match the next predicted write, in order.
  always @(negedge clk) begin
    logic [7:0]  a;
    logic [31:0] d;
    if (monEn) begin
      if (imem_we) begin
        if (expAddrQ.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          a = expAddrQ.pop_front();
          d = expDataQ.pop_front();
          checkOutput("write_addr", imem_addr, a);
          checkOutput("write_data", imem_wdata, d);
        end
        checkOutput("ready_during_write", in_ready, 0);
      end
      checkOutput("status_onehot", $countones({busy, done, error}) <= 1, 1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst   = 1'b1;
    monEn = 1'b1;
    @(negedge clk);

    // XOR of the eight data bytes is 0x55.
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    runScenario("s1", 1'b0, -1);
    checkOutput("s1_model_csum", expCsum, 8'h55);
    checkOutput("s1_done_lit", done, 1);
    checkOutput("s1_words_lit", words_loaded, 2);
    checkOutput("s1_addr_held", imem_addr, 1);
    checkOutput("s1_wdata_held", imem_wdata, 32'h01095020);

    stream[10] = 8'h00;
    runScenario("s2", 1'b0, -1);
    checkOutput("s2_error_lit", error, 1);

    stream = '{8'h01, 8'h01};
    buildModel(expDone, expErr, expWords, expCsum);
    applyStimulus(1'b0, -1);
    checkOutput("s3_error_now", error, 1);
    checkOutput("s3_ready_now", in_ready, 0);
    checkLoad("s3");

    stream = '{8'h00, 8'h00, 8'h00};
    runScenario("s4", 1'b0, -1);
    checkOutput("s4_words_lit", words_loaded, 0);

    // Three-word load cut by reset after two bytes of the second word.
    stream = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expAddrQ.push_back(8'h00);
    expDataQ.push_back(32'h11223344);
    applyStimulus(1'b0, -1);
    checkOutput("s5_busy_before_reset", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    checkResetState("s5_reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("s5_writes_left", expAddrQ.size(), 0);
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    runScenario("s5_reload", 1'b0, -1);

    runScenario("s6", 1'b1, 5);
    checkOutput("s6_done_lit", done, 1);
    checkOutput("s6_wdata_held", imem_wdata, 32'h01095020);

    monEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
